// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 hex keypad one column at a time, debounces
// whole-matrix scan results and hands clean key presses to a consumer over a
// valid/ready handshake.
// Optional feature: define KEYPAD_REPEAT_EN to build the auto-repeat logic.
// Without it, each clean press yields exactly one event.
module hex_keypad_scanner #(
  parameter int CLOCKFREQ      = 100,   // MHz
  parameter int SCAN_US        = 1000,  // per-column dwell in us
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_o,
  output logic       key_valid_o,
  input  logic       key_ready_i,
  output logic       key_held_o,
  output logic       overrun_o
);

  localparam int DWELL_CYCLES = CLOCKFREQ * SCAN_US;
  localparam int DWELL_W      = $clog2(DWELL_CYCLES);
  localparam int SCAN_MAX     = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS : REPEAT_SCANS;
  localparam int SCAN_W       = $clog2(SCAN_MAX + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [SCAN_W-1:0]  DEB_MAX    = SCAN_W'(DEBOUNCE_SCANS);

  // Scan result classification
  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  logic [3:0]         row_meta, row_sync;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [1:0]         col_idx;
  logic               dwell_last, scan_done;
  logic [3:0]         pressed_now;
  logic [11:0]        samp_q;       // pressed flags of columns 0..2, bit c*4+r
  logic [15:0]        scan_mat;
  logic [1:0]         res_kind;
  logic [3:0]         res_code;     // zero unless res_kind is SINGLE
  logic [1:0]         prev_kind, stable_kind;
  logic [3:0]         prev_code;
  logic [SCAN_W-1:0]  match_cnt, match_next;
  logic               becomes_stable, press_ev;
  logic               key_ev;
  logic [3:0]         ev_code;
  logic               xfer;

  // Key code for matrix position idx = column*4 + row
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:  key_map = 4'h1;  4'd1:  key_map = 4'h4;  4'd2:  key_map = 4'h7;  4'd3:  key_map = 4'h0;
      4'd4:  key_map = 4'h2;  4'd5:  key_map = 4'h5;  4'd6:  key_map = 4'h8;  4'd7:  key_map = 4'hF;
      4'd8:  key_map = 4'h3;  4'd9:  key_map = 4'h6;  4'd10: key_map = 4'h9;  4'd11: key_map = 4'hE;
      4'd12: key_map = 4'hA;  4'd13: key_map = 4'hB;  4'd14: key_map = 4'hC;  default: key_map = 4'hD;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous row lines, idle high
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst_i) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_i;
      row_sync <= row_meta;
    end
  end

  assign dwell_last  = (dwell_cnt == DWELL_LAST);
  assign scan_done   = dwell_last && (col_idx == 2'd3);
  assign pressed_now = ~row_sync;
  assign col_o       = ~(4'b0001 << col_idx);

  // Column dwell counter and column index stepping 0->1->2->3->0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
    end else if (dwell_last) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  // Capture rows of columns 0..2 on the last dwell cycle; column 3 is used live
  always_ff @(posedge clk_i) begin
    // NOTE: sample storage has no reset: every slot is rewritten before the
    // column-3 sample that consumes it, so reset would only add fan-out.
    if (dwell_last) begin
      case (col_idx)
        2'd0:    samp_q[3:0]  <= pressed_now;
        2'd1:    samp_q[7:4]  <= pressed_now;
        2'd2:    samp_q[11:8] <= pressed_now;
        default: ;
      endcase
    end
  end

  assign scan_mat = {pressed_now, samp_q};

  // Classify the full matrix as NONE, SINGLE(code) or MULTI
  always_comb begin
    logic seen, multi;
    logic [3:0] code;
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    seen     = 1'b0;
    multi    = 1'b0;
    code     = 4'h0;
    res_kind = RES_NONE;
    res_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (scan_mat[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        code = key_map(4'(i));
      end
    end
    if (multi) begin
      res_kind = RES_MULTI;
    end else if (seen) begin
      res_kind = RES_SINGLE;
      res_code = code;
    end
  end

  // Next match count: saturating run length of identical scan results
  always_comb begin
    if ((res_kind != prev_kind) || (res_code != prev_code)) begin
      match_next = SCAN_W'(1);
    end else if (match_cnt == DEB_MAX) begin
      match_next = DEB_MAX;
    end else begin
      match_next = match_cnt + 1'b1;
    end
  end

  assign becomes_stable = (match_next == DEB_MAX);
  assign press_ev = scan_done && becomes_stable &&
                    (stable_kind == RES_NONE) && (res_kind == RES_SINGLE);
  assign key_held_o = (stable_kind == RES_SINGLE);

  // Debounce state: previous result, match counter, stable classification
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_kind   <= RES_NONE;
      prev_code   <= 4'h0;
      match_cnt   <= '0;
      stable_kind <= RES_NONE;
    end else if (scan_done) begin
      prev_kind <= res_kind;
      prev_code <= res_code;
      match_cnt <= match_next;
      if (becomes_stable) stable_kind <= res_kind;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [SCAN_W-1:0] REP_LAST = SCAN_W'(REPEAT_SCANS - 1);

  logic [3:0]        stable_code;
  logic [SCAN_W-1:0] rep_cnt;
  logic              rep_armed, stays, rep_ev;

  // Stable state is still the same SINGLE key after this scan
  assign stays = (stable_kind == RES_SINGLE) &&
                 !(becomes_stable && ((res_kind != RES_SINGLE) || (res_code != stable_code)));
  assign rep_ev  = scan_done && rep_armed && stays && (rep_cnt == REP_LAST);
  assign key_ev  = press_ev | rep_ev;
  assign ev_code = press_ev ? res_code : stable_code;

  // Repeat timer: armed by a press event, counts scans while the key stays held
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_code <= 4'h0;
      rep_cnt     <= '0;
      rep_armed   <= 1'b0;
    end else if (scan_done) begin
      if (becomes_stable) stable_code <= res_code;
      if (press_ev) begin
        rep_armed <= 1'b1;
        rep_cnt   <= '0;
      end else if (!stays) begin
        rep_armed <= 1'b0;
        rep_cnt   <= '0;
      end else if (rep_cnt == REP_LAST) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  assign key_ev  = press_ev;
  assign ev_code = res_code;
`endif

  assign xfer = key_valid_o && key_ready_i;

  // Output holding register with valid/ready handshake and overrun detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_o       <= 4'h0;
      key_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (key_ev) begin
        if (!key_valid_o || xfer) begin
          key_o       <= ev_code;
          key_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (xfer) begin
        key_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner: keypad model driving row_i from col_o, a scoreboard
// of expected key codes popped on each handshake transfer, a table of all 16
// keys, and hand-written sequences for debounce, backpressure, rollover,
// repeat and reset corners. DWELL_CYCLES=4, so one full scan is 16 cycles.
module tb_hex_keypad_scanner;

  localparam int SCAN = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_o;
  logic       key_valid_o;
  logic       key_ready_i = 1'b1;
  logic       key_held_o;
  logic       overrun_o;

  logic [15:0] keys = '0;   // pressed keys, bit r*4+c
  logic [3:0]  exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          events_seen  = 0;
  int          overrun_seen = 0;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[16];

  hex_keypad_scanner #(
    .CLOCKFREQ(1), .SCAN_US(4), .DEBOUNCE_SCANS(4), .REPEAT_SCANS(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .row_i(row_i), .col_o(col_o),
    .key_o(key_o), .key_valid_o(key_valid_o), .key_ready_i(key_ready_i),
    .key_held_o(key_held_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Passive matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r*4 + c);
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    tick(3);
    rst_i = 1'b0;
  endtask

  // Scoreboard: a transfer occurs on the next edge whenever valid && ready
  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && key_valid_o === 1'b1 && key_ready_i === 1'b1) begin
      events_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_key", {28'd0, key_o}, 32'hFFFF_FFFF);
      end else begin
        check("key_code", {28'd0, key_o}, {28'd0, exp_q.pop_front()});
      end
    end
    if (overrun_o === 1'b1) overrun_seen++;
  end

  initial begin
    int ev0, ov0;

    vecs[0]  = '{0, 0, 4'h1}; vecs[1]  = '{0, 1, 4'h2}; vecs[2]  = '{0, 2, 4'h3}; vecs[3]  = '{0, 3, 4'hA};
    vecs[4]  = '{1, 0, 4'h4}; vecs[5]  = '{1, 1, 4'h5}; vecs[6]  = '{1, 2, 4'h6}; vecs[7]  = '{1, 3, 4'hB};
    vecs[8]  = '{2, 0, 4'h7}; vecs[9]  = '{2, 1, 4'h8}; vecs[10] = '{2, 2, 4'h9}; vecs[11] = '{2, 3, 4'hC};
    vecs[12] = '{3, 0, 4'h0}; vecs[13] = '{3, 1, 4'hF}; vecs[14] = '{3, 2, 4'hE}; vecs[15] = '{3, 3, 4'hD};

    // Reset values and column stepping
    do_reset();
    check("rst_col", {28'd0, col_o}, 32'hE);
    check("rst_key", {28'd0, key_o}, 32'h0);
    check("rst_valid", {31'd0, key_valid_o}, 32'd0);
    check("rst_held", {31'd0, key_held_o}, 32'd0);
    check("rst_overrun", {31'd0, overrun_o}, 32'd0);
    tick(1);
    check("col0_dwell", {28'd0, col_o}, 32'hE);
    tick(3);
    check("col1", {28'd0, col_o}, 32'hD);
    tick(4);
    check("col2", {28'd0, col_o}, 32'hB);
    tick(4);
    check("col3", {28'd0, col_o}, 32'h7);
    tick(4);
    check("col_wrap", {28'd0, col_o}, 32'hE);

    // Clean press of '5' with exact event latency
    do_reset();
    ev0 = events_seen;
    keys = key_bit(1, 1);
    exp_q.push_back(4'h5);
    tick(4*SCAN - 1);
    check("press_valid_early", {31'd0, key_valid_o}, 32'd0);
    check("press_held_early", {31'd0, key_held_o}, 32'd0);
    tick(1);
    check("press_valid", {31'd0, key_valid_o}, 32'd1);
    check("press_key", {28'd0, key_o}, 32'h5);
    check("press_held", {31'd0, key_held_o}, 32'd1);
    tick(1);
    check("press_valid_one_cycle", {31'd0, key_valid_o}, 32'd0);
    tick(6*SCAN - 4*SCAN - 1);
    check("press_held_6", {31'd0, key_held_o}, 32'd1);
    check("press_events", events_seen - ev0, 32'd1);
    keys = '0;
    tick(3*SCAN);
    check("release_held_3", {31'd0, key_held_o}, 32'd1);
    tick(SCAN);
    check("release_held_4", {31'd0, key_held_o}, 32'd0);

    // Table: every key maps to its hex code, one event per press
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ev0 = events_seen;
      keys = key_bit(vecs[i].r, vecs[i].c);
      exp_q.push_back(vecs[i].code);
      tick(5*SCAN);
      check("tbl_held", {31'd0, key_held_o}, 32'd1);
      check("tbl_events", events_seen - ev0, 32'd1);
      keys = '0;
      tick(5*SCAN);
      check("tbl_released", {31'd0, key_held_o}, 32'd0);
    end

    // Bounce: '9' released/pressed/released, then pressed steadily
    do_reset();
    ev0 = events_seen;
    exp_q.push_back(4'h9);
    keys = '0;            tick(SCAN);
    keys = key_bit(2, 2); tick(SCAN);
    keys = '0;            tick(SCAN);
    keys = key_bit(2, 2); tick(3*SCAN);
    check("bounce_no_early_event", events_seen - ev0, 32'd0);
    tick(2*SCAN);
    check("bounce_events", events_seen - ev0, 32'd1);
    keys = '0;
    tick(5*SCAN);

    // Backpressure: 'A' pending, '0' press is dropped with an overrun pulse
    do_reset();
    key_ready_i = 1'b0;
    ev0 = events_seen;
    ov0 = overrun_seen;
    exp_q.push_back(4'hA);
    keys = key_bit(0, 3); tick(5*SCAN);
    check("bp_valid", {31'd0, key_valid_o}, 32'd1);
    check("bp_key_a", {28'd0, key_o}, 32'hA);
    keys = '0;            tick(5*SCAN);
    keys = key_bit(3, 0); tick(5*SCAN);
    check("bp_key_kept", {28'd0, key_o}, 32'hA);
    check("bp_valid_kept", {31'd0, key_valid_o}, 32'd1);
    check("bp_overrun_pulses", overrun_seen - ov0, 32'd1);
    key_ready_i = 1'b1;
    tick(1);
    check("bp_valid_fall", {31'd0, key_valid_o}, 32'd0);
    check("bp_events", events_seen - ev0, 32'd1);
    keys = '0;
    tick(5*SCAN);

    // Rollover: '1'+'2' together, then '2' released -> never an event
    do_reset();
    ev0 = events_seen;
    keys = key_bit(0, 0) | key_bit(0, 1);
    tick(5*SCAN);
    check("multi_held", {31'd0, key_held_o}, 32'd0);
    keys = key_bit(0, 0);
    tick(3*SCAN);
    check("multi_single_3", {31'd0, key_held_o}, 32'd0);
    tick(SCAN);
    check("multi_single_4", {31'd0, key_held_o}, 32'd1);
    check("multi_events", events_seen - ev0, 32'd0);
    keys = '0;
    tick(5*SCAN);

    // Hold 'F' for 30 scans: repeats only when the repeat feature is built
    do_reset();
    ev0 = events_seen;
    keys = key_bit(3, 1);
`ifdef KEYPAD_REPEAT_EN
    repeat (4) exp_q.push_back(4'hF);
`else
    exp_q.push_back(4'hF);
`endif
    tick(12*SCAN - 1);
    check("hold_valid_before_12", {31'd0, key_valid_o}, 32'd0);
    tick(1);
`ifdef KEYPAD_REPEAT_EN
    check("hold_repeat_at_12", {31'd0, key_valid_o}, 32'd1);
    check("hold_repeat_key", {28'd0, key_o}, 32'hF);
`else
    check("hold_no_repeat_at_12", {31'd0, key_valid_o}, 32'd0);
`endif
    tick(30*SCAN - 12*SCAN);
`ifdef KEYPAD_REPEAT_EN
    check("hold_events", events_seen - ev0, 32'd4);
`else
    check("hold_events", events_seen - ev0, 32'd1);
`endif
    keys = '0;
    tick(5*SCAN);

    // Reset while a key is pending aborts it and restarts debouncing
    do_reset();
    key_ready_i = 1'b0;
    ev0 = events_seen;
    keys = key_bit(3, 1);
    tick(4*SCAN);
    check("mid_valid_before_rst", {31'd0, key_valid_o}, 32'd1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    check("mid_rst_valid", {31'd0, key_valid_o}, 32'd0);
    check("mid_rst_held", {31'd0, key_held_o}, 32'd0);
    check("mid_rst_col", {28'd0, col_o}, 32'hE);
    exp_q.push_back(4'hF);
    tick(4*SCAN - 1);
    check("mid_no_early_event", {31'd0, key_valid_o}, 32'd0);
    tick(1);
    check("mid_event_valid", {31'd0, key_valid_o}, 32'd1);
    check("mid_event_key", {28'd0, key_o}, 32'hF);
    key_ready_i = 1'b1;
    tick(1);
    check("mid_transfer", {31'd0, key_valid_o}, 32'd0);
    check("mid_events", events_seen - ev0, 32'd1);
    keys = '0;
    tick(5*SCAN);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
